md5_job_scheduler: RTL

MD5_JOB_SCHEDULER -- requirements
Module: md5_job_scheduler

---
 rtl/md5_sched_pkg.sv | 20 ++
 rtl/md5_msg_buffer.sv | 34 +++
 rtl/md5_job_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/md5_sched_pkg.sv
// Shared types and constants for the MD5 job scheduler and its message buffer.
package md5_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } sched_state_t;

    localparam int BEATS_PER_BLOCK = 8;
    localparam int WORD_BITS       = 64;
    localparam int DIGEST_BITS     = 128;

    localparam logic [63:0] DEF_IN_BASE  = 64'h0000_0000_4000_0000;
    localparam logic [63:0] DEF_OUT_BASE = 64'h0000_0000_4000_0100;
    localparam int          DEF_TIMEOUT  = 65535;

endpackage

// File: rtl/md5_msg_buffer.sv
// One 512-bit message block held as 8 x 64-bit words: a write port, a
// registered read port and a synchronous clear-all. Storage has no reset;
// a new job clears it explicitly.
module md5_msg_buffer
    import md5_sched_pkg::*;
(
    input  logic                               clk,
    input  logic                               clear,
    input  logic                               wr_en,
    input  logic [$clog2(BEATS_PER_BLOCK)-1:0] wr_addr,
    input  logic [WORD_BITS-1:0]               wr_data,
    input  logic                               rd_en,
    input  logic [$clog2(BEATS_PER_BLOCK)-1:0] rd_addr,
    output logic [WORD_BITS-1:0]               rd_data
);

    logic [WORD_BITS-1:0] mem [BEATS_PER_BLOCK];

    // Clear first so a write in the same cycle lands on top of the cleared block.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < BEATS_PER_BLOCK; i++) begin
                mem[i] <= '0;
            end
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/md5_job_scheduler.sv
// Collects one message block from a beat stream, kicks the MD5 core, serves
// the core's memory reads from the buffer, captures the digest it writes back
// and presents that digest on the result stream.
module md5_job_scheduler
    import md5_sched_pkg::*;
#(
    parameter logic [63:0] IN_BASE  = DEF_IN_BASE,
    parameter logic [63:0] OUT_BASE = DEF_OUT_BASE,
    parameter int          TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   msg_valid,
    output logic                   msg_ready,
    input  logic [WORD_BITS-1:0]   msg_data,
    input  logic                   msg_last,
    output logic                   digest_valid,
    input  logic                   digest_ready,
    output logic [DIGEST_BITS-1:0] digest_data,
    output logic                   busy,
    output logic                   error,
    output logic                   core_start,
    input  logic                   core_done,
    input  logic                   core_oe,
    input  logic [63:0]            core_addr,
    output logic [WORD_BITS-1:0]   core_rdata,
    output logic                   core_datardy,
    input  logic                   core_we,
    input  logic [WORD_BITS-1:0]   core_wdata,
    input  logic [11:0]            core_size,
    output logic [31:0]            core_in_ptr,
    output logic [31:0]            core_out_ptr
);

    localparam int                IDX_W    = $clog2(BEATS_PER_BLOCK);
    localparam int                WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BEATS_PER_BLOCK - 1);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [63:0]       WIN_SIZE = 64'(BEATS_PER_BLOCK * 8);
    localparam logic [63:0]       OUT_HI   = OUT_BASE + 64'd8;

    sched_state_t         state_q, state_d;
    logic [IDX_W-1:0]     load_idx;
    logic [WD_W-1:0]      watchdog;
    logic                 rd_hit;
    logic [WORD_BITS-1:0] buf_rdata;
    logic [63:0]          rd_offset;
    logic                 beat_accept, first_beat;
    logic                 in_run, core_rd, core_wr;
    logic                 wr_lo, wr_hi, wr_good, wr_bad;
    logic                 rd_in_window, buf_rd_en, timeout_hit;

    assign core_in_ptr  = IN_BASE[31:0];
    assign core_out_ptr = OUT_BASE[31:0];

    assign beat_accept = msg_valid && msg_ready;
    assign first_beat  = beat_accept && (state_q == S_IDLE);

    assign in_run  = (state_q == S_RUN);
    assign core_rd = in_run && core_oe;
    assign core_wr = in_run && core_we;

    assign wr_lo   = (core_addr == OUT_BASE);
    assign wr_hi   = (core_addr == OUT_HI);
    assign wr_good = core_wr && (core_size == 12'd64) && (wr_lo || wr_hi);
    assign wr_bad  = core_wr && !wr_good;

    // Addresses below IN_BASE wrap to huge offsets, so one compare bounds both sides.
    assign rd_offset    = core_addr - IN_BASE;
    assign rd_in_window = (rd_offset < WIN_SIZE);
    assign buf_rd_en    = core_rd && !core_we && rd_in_window;

    assign timeout_hit = in_run && (watchdog == WD_LAST);

    assign core_rdata = rd_hit ? buf_rdata : '0;

    md5_msg_buffer u_buffer (
        .clk     (clk),
        .clear   (first_beat),
        .wr_en   (beat_accept),
        .wr_addr (load_idx),
        .wr_data (msg_data),
        .rd_en   (buf_rd_en),
        .rd_addr (rd_offset[5:3]),
        .rd_data (buf_rdata)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs for the job sequence.
    always_comb begin
        state_d      = state_q;
        msg_ready    = 1'b0;
        busy         = 1'b1;
        core_start   = 1'b0;
        digest_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                msg_ready = 1'b1;
                busy      = 1'b0;
                if (msg_valid) state_d = msg_last ? S_START : S_LOAD;
            end
            S_LOAD: begin
                msg_ready = 1'b1;
                if (msg_valid && (msg_last || load_idx == IDX_LAST)) state_d = S_START;
            end
            S_START: begin
                core_start = 1'b1;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (core_done || timeout_hit) state_d = S_DONE;
            end
            S_DONE: begin
                digest_valid = 1'b1;
                if (digest_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Word pointer for incoming beats; returns to 0 whenever a block is closed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_idx <= '0;
        end else if (beat_accept) begin
            load_idx <= (state_d == S_LOAD) ? load_idx + 1'b1 : '0;
        end
    end

    // Watchdog restarts at START and counts every RUN cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            watchdog <= '0;
        end else if (state_q == S_START) begin
            watchdog <= '0;
        end else if (in_run) begin
            watchdog <= watchdog + 1'b1;
        end
    end

    // Core bus responses, digest capture and the sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_datardy <= 1'b0;
            rd_hit       <= 1'b0;
            digest_data  <= '0;
            error        <= 1'b0;
        end else begin
            core_datardy <= core_rd || core_wr;
            rd_hit       <= buf_rd_en;
            if (wr_good && wr_lo) digest_data[WORD_BITS-1:0]           <= core_wdata;
            if (wr_good && wr_hi) digest_data[DIGEST_BITS-1:WORD_BITS] <= core_wdata;
            if (first_beat) begin
                error <= 1'b0;
            end else if (wr_bad || (core_wr && core_oe) || timeout_hit) begin
                error <= 1'b1;
            end
        end
    end

endmodule
